spi_slave_framed: RTL

Parametrised SPI slave, the next generation of the team's byte-wide SPI slave interface. Adds configurable word width, all four CPOL/CPHA modes and MSB/LSB-first order. Adds valid/ready handshakes on both RX and TX, with overrun/underrun flags and frame-level status (per-frame word count, frame end, partial-word error). Sits between the external SPI master pins and the on-chip controller, entirely in the clk_in domain.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave_framed.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and mode-decode helpers for the framed SPI slave.
// Maps CPOL/CPHA onto the SCLK edge that samples MOSI and the edge that shifts MISO.
package spi_pkg;

  typedef enum logic [0:0] {StIdle, StSel} sel_state_e;

  typedef enum logic [0:0] {EdgeRise, EdgeFall} edge_e;

  function automatic edge_e other_edge(input edge_e e);
    return (e == EdgeRise) ? EdgeFall : EdgeRise;
  endfunction

  function automatic edge_e lead_edge(input bit cpol);
    return cpol ? EdgeFall : EdgeRise;
  endfunction

  function automatic edge_e sample_edge(input bit cpol, input bit cpha);
    return cpha ? other_edge(lead_edge(cpol)) : lead_edge(cpol);
  endfunction

  // Word bit position for the cnt-th bit on the wire.
  function automatic int unsigned bit_index(input int unsigned cnt, input bit msb_first,
                                            input int unsigned width);
    return msb_first ? (width - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one extra delay stage for rise/fall pulse detection.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~dly_q;
  assign fall_o = ~q_o & dly_q;

endmodule

// File: rtl/spi_slave_framed.sv
// Parametrised SPI slave: any CPOL/CPHA, MSB/LSB first, valid/ready on RX and TX,
// plus per-frame status. Everything runs in the clk_in domain off synchronised pins.
module spi_slave_framed
  import spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter bit                    CPOL        = 1'b0,
  parameter bit                    CPHA        = 1'b0,
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE     = '0,
  parameter int unsigned           COUNT_WIDTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   spi_sclk,
  input  logic                   spi_mosi,
  input  logic                   spi_n_ss,
  output logic                   spi_miso,
  output logic                   spi_miso_oe,
  input  logic [DATA_WIDTH-1:0]  tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx_underrun,
  output logic [DATA_WIDTH-1:0]  rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   rx_overrun,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   frame_error,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int unsigned CntW       = $clog2(DATA_WIDTH);
  localparam edge_e       SampleEdge = sample_edge(CPOL, CPHA);
  localparam int unsigned ArmW       = $clog2(SYNC_STAGES + 2);
  localparam logic [ArmW-1:0] ArmLast = ArmW'(SYNC_STAGES);

  function automatic logic [CntW-1:0] idx(input logic [CntW-1:0] cnt);
    return CntW'(bit_index(32'(cnt), MSB_FIRST, DATA_WIDTH));
  endfunction

  logic sclk_rise, sclk_fall, unused_sclk_q;
  logic nss_sync, nss_fall, unused_nss_rise;
  logic mosi_sync, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_i    (spi_sclk),
    .q_o    (unused_sclk_q),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nss (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_i    (spi_n_ss),
    .q_o    (nss_sync),
    .rise_o (unused_nss_rise),
    .fall_o (nss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_i    (spi_mosi),
    .q_o    (mosi_sync),
    .rise_o (unused_mosi_rise),
    .fall_o (unused_mosi_fall)
  );

  logic samp_ev, shift_ev;
  assign samp_ev  = (SampleEdge == EdgeRise) ? sclk_rise : sclk_fall;
  assign shift_ev = (SampleEdge == EdgeRise) ? sclk_fall : sclk_rise;

  sel_state_e             state_q, state_d;
  logic                   nss_prev_q, nss_prev_d;
  logic                   armed_q, armed_d;
  logic [ArmW-1:0]        arm_cnt_q, arm_cnt_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   rx_overrun_q, rx_overrun_d;
  logic                   frame_start_q, frame_start_d;
  logic                   frame_end_q, frame_end_d;
  logic                   frame_error_q, frame_error_d;

  logic                   tx_load, word_done;
  logic [DATA_WIDTH-1:0]  tx_word, rx_word;

  always_comb begin
    state_d       = state_q;
    nss_prev_d    = nss_sync;
    armed_d       = armed_q;
    arm_cnt_d     = arm_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    word_count_d  = word_count_q;
    tx_ready_d    = 1'b0;
    tx_underrun_d = 1'b0;
    rx_overrun_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_error_d = 1'b0;
    tx_load       = 1'b0;
    word_done     = 1'b0;
    tx_word       = TX_IDLE;
    rx_word       = rx_shift_q;

    // The synchroniser restarts high after reset, so a still-low n_ss shows up as a
    // fall. Only accept frames once n_ss has been seen high for longer than that.
    if (!armed_q) begin
      if (nss_sync) begin
        if (arm_cnt_q == ArmLast) armed_d = 1'b1;
        else                      arm_cnt_d = arm_cnt_q + 1'b1;
      end else begin
        arm_cnt_d = '0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (armed_q && nss_fall) begin
          state_d       = StSel;
          frame_start_d = 1'b1;
          word_count_d  = '0;
          bit_cnt_d     = '0;
          miso_oe_d     = 1'b1;
          tx_load       = !CPHA;
        end
      end
      StSel: begin
        if (nss_sync && nss_prev_q) begin
          state_d       = StIdle;
          frame_end_d   = 1'b1;
          frame_error_d = (bit_cnt_q != '0);
          miso_oe_d     = 1'b0;
          miso_d        = 1'b0;
          bit_cnt_d     = '0;
        end else if (shift_ev) begin
          if (bit_cnt_q == '0) tx_load = 1'b1;
          else                 miso_d  = tx_shift_q[idx(bit_cnt_q)];
        end else if (samp_ev) begin
          rx_word[idx(bit_cnt_q)] = mosi_sync;
          rx_shift_d = rx_word;
          if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
            if (word_count_q != {COUNT_WIDTH{1'b1}}) word_count_d = word_count_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (tx_load) begin
      if (tx_valid) begin
        tx_word    = tx_data;
        tx_ready_d = 1'b1;
      end else begin
        tx_underrun_d = 1'b1;
      end
      tx_shift_d = tx_word;
      miso_d     = tx_word[idx('0)];
    end

    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      nss_prev_q    <= 1'b1;
      armed_q       <= 1'b0;
      arm_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      word_count_q  <= '0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      nss_prev_q    <= nss_prev_d;
      armed_q       <= armed_d;
      arm_cnt_q     <= arm_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      word_count_q  <= word_count_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
      rx_overrun_q  <= rx_overrun_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_error = frame_error_q;
  assign word_count  = word_count_q;

endmodule
